// File: rtl/bg_seq_pkg.sv
// Shared encodings and helpers for the background layer sequencer.
// Layers are one-hot {bg3,bg2,bg1}; 000 means a black screen.
package bg_seq_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    localparam logic [2:0] LAYER_NONE = 3'b000;
    localparam logic [2:0] LAYER_BG1  = 3'b001;
    localparam logic [2:0] LAYER_BG2  = 3'b010;
    localparam logic [2:0] LAYER_BG3  = 3'b100;

    localparam int H_ACTIVE_DEF = 640;

    function automatic logic [1:0] pop3(input logic [2:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
    endfunction

    // First set bit strictly after 'from' in bg1->bg2->bg3 order,
    // wrapping around; from=000 starts the search at bg1.
    function automatic logic [2:0] next_layer(input logic [2:0] m,
                                              input logic [2:0] from);
        logic [2:0] r;
        r = LAYER_NONE;
        if (from == LAYER_BG1) begin
            if (m[1])      r = LAYER_BG2;
            else if (m[2]) r = LAYER_BG3;
            else if (m[0]) r = LAYER_BG1;
        end else if (from == LAYER_BG2) begin
            if (m[2])      r = LAYER_BG3;
            else if (m[0]) r = LAYER_BG1;
            else if (m[1]) r = LAYER_BG2;
        end else begin
            if (m[0])      r = LAYER_BG1;
            else if (m[1]) r = LAYER_BG2;
            else if (m[2]) r = LAYER_BG3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_layer_sequencer_scroll.sv
// Horizontal scroll accumulator, wrapping modulo the visible width.
// Clear has priority over advance.
module bg_scroll_accum
    import bg_seq_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] step,
    input  logic       advance,
    input  logic       clear,
    output logic [9:0] pos
);

    localparam logic [10:0] WRAP = 11'(H_ACTIVE);

    logic [10:0] sum;
    logic [10:0] wrapped;

    assign sum     = {1'b0, pos} + {7'd0, step};
    assign wrapped = sum - WRAP;

    // Offset register: cleared on layer change, stepped once per frame
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos <= '0;
        end else if (advance) begin
            pos <= (sum >= WRAP) ? wrapped[9:0] : sum[9:0];
        end
    end

endmodule

// File: rtl/bg_layer_sequencer.sv
// Frame-synchronous background layer sequencer: layer choice, blank
// frame between layers, auto rotation, scroll offset, sticky irq.
module bg_layer_sequencer
    import bg_seq_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int DWELL_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [2:0]         req_mask,
    input  logic               auto_cycle,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         scroll_step,
    input  logic               irq_clear,
    input  logic               vsync,
    output logic               vga_en,
    output logic [2:0]         layer_sel,
    output logic [9:0]         scroll_x,
    output logic [7:0]         frame_cnt,
    output logic               irq
);

    logic               vsync_q;
    logic               vsync_rise;
    logic               frame_go;
    logic [1:0]         state;
    logic [2:0]         cur;
    logic [2:0]         rot;
    logic [2:0]         target;
    logic [2:0]         hold_l;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_m1;
    logic               rotate;
    logic               err;
    logic               advance;
    logic               clear;

    assign vsync_rise = vsync & ~vsync_q;
    assign frame_go   = vsync_rise & enable & (state != ST_IDLE);
    assign dwell_m1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    // >= keeps rotation alive if dwell shrinks below the running count
    assign rotate     = ((state == ST_RUN) || (state == ST_SWITCH))
                        && (dwell_cnt >= dwell_m1);

    // Target layer for this frame from the mask and the rotation pointer
    always_comb begin
        err    = 1'b0;
        target = LAYER_NONE;
        hold_l = ((rot & req_mask) != LAYER_NONE) ? rot
                                                  : next_layer(req_mask, rot);
        if (auto_cycle) begin
            target = rotate ? next_layer(req_mask, rot) : hold_l;
        end else if (pop3(req_mask) == 2'd1) begin
            target = req_mask;
        end else begin
            err = (pop3(req_mask) > 2'd1);
        end
    end

    assign advance = frame_go && (state == ST_RUN)
                     && (target == cur) && (cur != LAYER_NONE);
    assign clear   = !enable || (frame_go && (state == ST_SWITCH));

    // Sequencer FSM, frame counter, dwell counter and rotation pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            state     <= ST_IDLE;
            cur       <= LAYER_NONE;
            rot       <= LAYER_NONE;
            dwell_cnt <= '0;
            vga_en    <= 1'b0;
            layer_sel <= LAYER_NONE;
            frame_cnt <= '0;
        end else begin
            vsync_q <= vsync;
            if (!enable) begin
                state     <= ST_IDLE;
                cur       <= LAYER_NONE;
                rot       <= LAYER_NONE;
                dwell_cnt <= '0;
                vga_en    <= 1'b0;
                layer_sel <= LAYER_NONE;
                frame_cnt <= '0;
            end else if (state == ST_IDLE) begin
                state  <= ST_ARM;
                vga_en <= 1'b1;
            end else if (vsync_rise) begin
                frame_cnt <= frame_cnt + 8'd1;
                // manual mode parks the pointer so auto restarts at bg1
                rot <= auto_cycle ? target : LAYER_NONE;
                if (!auto_cycle || rotate || (state == ST_ARM)) begin
                    dwell_cnt <= '0;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
                case (state)
                    ST_ARM, ST_SWITCH: begin
                        state     <= ST_RUN;
                        cur       <= target;
                        layer_sel <= target;
                    end
                    ST_RUN: begin
                        if (target != cur) begin
                            state     <= ST_SWITCH;
                            layer_sel <= LAYER_NONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky misconfiguration flag; a new error beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (frame_go && err) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end

    bg_scroll_accum #(
        .H_ACTIVE(H_ACTIVE)
    ) u_scroll (
        .clk    (clk),
        .rst    (rst),
        .step   (scroll_step),
        .advance(advance),
        .clear  (clear),
        .pos    (scroll_x)
    );

endmodule

// File: tb/tb_bg_layer_sequencer.sv
// Self-checking bench for bg_layer_sequencer against a frame-level
// behavioural model (layer index, scroll position, frame counter).
module tb_bg_layer_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] req_mask;
    logic       auto_cycle;
    logic [7:0] dwell;
    logic [3:0] scroll_step;
    logic       irq_clear;
    logic       vsync;
    logic       vga_en;
    logic [2:0] layer_sel;
    logic [9:0] scroll_x;
    logic [7:0] frame_cnt;
    logic       irq;

    int n_assert = 0;
    int n_fail   = 0;

    // model: layers as indices 1..3, 0 = black
    bit m_on, m_first, m_blank, m_irq;
    int m_cur, m_idx, m_cnt, m_pos, m_frames;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bg_layer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_mask   (req_mask),
        .auto_cycle (auto_cycle),
        .dwell      (dwell),
        .scroll_step(scroll_step),
        .irq_clear  (irq_clear),
        .vsync      (vsync),
        .vga_en     (vga_en),
        .layer_sel  (layer_sel),
        .scroll_x   (scroll_x),
        .frame_cnt  (frame_cnt),
        .irq        (irq)
    );

    function automatic int onehot(int i);
        return (i == 0) ? 0 : (1 << (i - 1));
    endfunction

    function automatic int next_after(logic [2:0] m, int i);
        int j;
        for (int k = 0; k < 3; k++) begin
            j = (i == 0) ? k + 1 : ((i + k) % 3) + 1;
            if (m[j-1]) return j;
        end
        return 0;
    endfunction

    function automatic int shown();
        if (!m_on || m_first || m_blank) return 0;
        return onehot(m_cur);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".vga"},   32'(vga_en),    32'(m_on));
        chk({tag, ".layer"}, 32'(layer_sel), shown());
        chk({tag, ".scroll"},32'(scroll_x),  m_pos);
        chk({tag, ".frame"}, 32'(frame_cnt), m_frames);
        chk({tag, ".irq"},   32'(irq),       32'(m_irq));
    endtask

    task automatic model_clear();
        m_first = 1'b0;
        m_blank = 1'b0;
        m_cur = 0;
        m_idx = 0;
        m_cnt = 0;
        m_pos = 0;
        m_frames = 0;
    endtask

    task automatic model_frame(logic [2:0] m, bit clr);
        int tgt;
        int d;
        bit err;
        err = 1'b0;
        tgt = 0;
        if (!auto_cycle) begin
            m_idx = 0;
            m_cnt = 0;
            if ($countones(m) == 1) tgt = m[0] ? 1 : (m[1] ? 2 : 3);
            else err = ($countones(m) > 1);
        end else begin
            d = (dwell == 8'd0) ? 1 : int'(dwell);
            if (!m_first && m_cnt >= d - 1) begin
                m_cnt = 0;
                m_idx = next_after(m, m_idx);
            end else begin
                if (!m_first) m_cnt++;
                if (m_idx == 0 || !m[m_idx-1]) m_idx = next_after(m, m_idx);
            end
            tgt = m_idx;
        end
        if (m_first) begin
            m_cur = tgt;
            m_first = 1'b0;
        end else if (m_blank) begin
            m_cur = tgt;
            m_pos = 0;
            m_blank = 1'b0;
        end else if (tgt != m_cur) begin
            m_blank = 1'b1;
        end else if (m_cur != 0) begin
            m_pos = (m_pos + int'(scroll_step)) % 640;
        end
        m_frames = (m_frames + 1) % 256;
        if (err) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
    endtask

    // one video frame: 2-cycle vsync pulse, then a blanking gap in
    // which the mask is scrambled to prove it is only sampled at vsync
    task automatic frame(logic [2:0] m, bit clr, string tag);
        req_mask = m;
        irq_clear = clr;
        vsync = 1'b1;
        @(negedge clk);
        model_frame(m, clr);
        check_all(tag);
        irq_clear = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        req_mask = 3'($urandom_range(0, 7));
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".hold"}, 32'(layer_sel), shown());
        @(negedge clk);
    endtask

    task automatic set_enable(bit v, string tag);
        enable = v;
        @(negedge clk);
        model_clear();
        m_on = v;
        m_first = v;
        check_all(tag);
    endtask

    task automatic clear_irq(logic [2:0] m);
        req_mask = m;
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        m_irq = 1'b0;
        check_all("irqclr");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        m_on = 1'b0;
        m_irq = 1'b0;
        check_all("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        m_on = enable;
        m_first = enable;
        check_all("rst_rearm");
    endtask

    int exp_seq [6];
    logic [2:0] mask_r;

    initial begin
        exp_seq = '{1, 1, 0, 4, 0, 1};
        rst = 1'b1;
        enable = 1'b0;
        req_mask = 3'b000;
        auto_cycle = 1'b0;
        dwell = 8'd0;
        scroll_step = 4'd0;
        irq_clear = 1'b0;
        vsync = 1'b0;
        m_on = 1'b0;
        m_irq = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all("idle");

        // arm and first layer
        scroll_step = 4'd3;
        req_mask = 3'b001;
        set_enable(1'b1, "arm");
        repeat (3) @(negedge clk);
        chk("arm.black", 32'(layer_sel), 0);
        frame(3'b001, 1'b0, "t1.f0");
        chk("t1.bg1", 32'(layer_sel), 1);
        frame(3'b001, 1'b0, "t1.f1");
        frame(3'b001, 1'b0, "t1.f2");

        // manual switch with one blank frame
        frame(3'b010, 1'b0, "t2.blank");
        chk("t2.black", 32'(layer_sel), 0);
        frame(3'b010, 1'b0, "t2.bg2");
        chk("t2.sel", 32'(layer_sel), 2);
        chk("t2.scroll0", 32'(scroll_x), 0);

        // misconfiguration irq, set beats clear
        frame(3'b011, 1'b0, "t3.err");
        chk("t3.irq", 32'(irq), 1);
        frame(3'b011, 1'b1, "t3.setwins");
        chk("t3.irq_kept", 32'(irq), 1);
        clear_irq(3'b001);
        chk("t3.irq_cleared", 32'(irq), 0);

        // 50 frames of scrolling through the wrap
        scroll_step = 4'd15;
        frame(3'b001, 1'b0, "t4.settle0");
        frame(3'b001, 1'b0, "t4.settle1");
        for (int i = 1; i <= 50; i++) begin
            frame(3'b001, 1'b0, "t4.run");
            if (i == 42) chk("t4.pre_wrap", 32'(scroll_x), 630);
            if (i == 43) chk("t4.wrap", 32'(scroll_x), 5);
        end
        chk("t4.final", 32'(scroll_x), 110);

        // disable mid-frame
        vsync = 1'b0;
        set_enable(1'b0, "t6.off");
        chk("t6.vga", 32'(vga_en), 0);
        chk("t6.frame", 32'(frame_cnt), 0);
        chk("t6.scroll", 32'(scroll_x), 0);
        repeat (2) @(negedge clk);

        // auto rotation, dwell 2
        auto_cycle = 1'b1;
        dwell = 8'd2;
        scroll_step = 4'd7;
        req_mask = 3'b101;
        set_enable(1'b1, "t5.arm");
        for (int i = 0; i < 6; i++) begin
            frame(3'b101, 1'b0, "t5.auto");
            chk("t5.seq", 32'(layer_sel), exp_seq[i]);
        end

        // dwell 0 acts as dwell 1
        set_enable(1'b0, "t5.off");
        dwell = 8'd0;
        set_enable(1'b1, "t5.rearm");
        for (int i = 0; i < 6; i++) frame(3'b111, 1'b0, "t5.d0");

        // single-bit mask in auto mode never blanks
        set_enable(1'b0, "t5.off2");
        dwell = 8'd1;
        set_enable(1'b1, "t5.rearm2");
        for (int i = 0; i < 4; i++) begin
            frame(3'b010, 1'b0, "t5.single");
            chk("t5.single_sel", 32'(layer_sel), 2);
        end

        pulse_reset();

        // randomized traffic
        mask_r = 3'b001;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0)
                auto_cycle = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                dwell = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                mask_r = 3'($urandom_range(0, 7));
            scroll_step = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) begin
                set_enable(1'b0, "rnd.off");
                set_enable(1'b1, "rnd.on");
            end
            if ($urandom_range(0, 5) == 0) clear_irq(mask_r);
            frame(mask_r, 1'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
